periodic_stride_detector: RTL
=============================

Name: periodic_stride_detector

Overview:
- Parametrised successor to the two-stride detector.
- Learns repeating stride patterns of any period 1..MAX_PERIOD from a stream of 32-bit values, with signed strides and configurable confidence depth.
- Reports the shortest locked period, its strides rotated to next-expected order, and a predicted next value.
- Sits beside the prefetch/address-tracking logic that consumes stride hints.

Parameters:
- STRIDE_WIDTH, 5, signed stride width; representable range -2^(SW-1)..2^(SW-1)-1.
- MAX_PERIOD, 4, longest pattern period tracked; one detector per period P = 1..MAX_PERIOD.
- CONF_WIDTH, 2, saturating confidence counter width; lock when counter = 2^CW-1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- value_i  in  32  sample value.
- valid_i  in  1  sample strobe.
- clear_i  in  1  synchronous flush of all learned state.
- period_o  out  $clog2(MAX_PERIOD+1)  locked period; 0 = none.
- period_valid_o  out  1  some detector is fully locked.
- stride_o  out  MAX_PERIOD*STRIDE_WIDTH  slot i in bits [i*SW +: SW]; slot 0 = next expected stride.
- predict_o  out  32  predicted next value_i.
- predict_valid_o  out  1  equals period_valid_o.

Behaviour:
- Reset (async) and clear_i (sync) zero all state:
  - last_value, primed flag, every detector's phase, stride slots and confidences.
  - All outputs read 0.
- clear_i and valid_i in the same cycle: clear wins and the sample is discarded.
- Priming:
  - First accepted sample after reset or clear only loads last_value and sets primed; no training occurs.
  - Later accepted samples load last_value and train.
- Incoming stride:
  - inc_full = value_i - last_value, computed in 33 bits.
  - overflow = inc_full is not sign-representable in STRIDE_WIDTH bits, i.e. bits [32:SW-1] are not all equal.
  - inc = inc_full[SW-1:0].
- Detector P training, slot s = phase_q[P] (range 0..P-1). On each trained sample:
  - Match (inc == slot stride and !overflow): conf increments, saturating at max.
  - Else if conf > 0: conf decrements.
  - Else if !overflow: slot stride loads inc.
  - Else: no change.
  - Phase then advances: phase = (phase+1) mod P, wrapping P-1 -> 0.
- All detectors train in parallel on every trained sample.
- Lock: detector P is locked when all P of its confidences equal max.
- Selection:
  - period_o = smallest locked P; period_valid_o = 1 if any detector is locked.
  - stride_o slot i (i < P) = detector P stride[(phase_q[P]+i) mod P].
  - Slots i >= P, and every slot when unlocked, read 0.
- predict_o = last_value + sign_extend(stride_o slot 0), modulo 2^32; 0 when unlocked.
- Latency: outputs are combinational from registers. A sample accepted at edge t is reflected after edge t.
- valid_i low: no state change.

Test Plan:
- Lock on stride +4:
  - Stimulus: reset, then valid values 100, 104, 108, 112, 116 on consecutive cycles.
  - Response: after the 116 edge, period_o=1, period_valid_o=1, stride_o slot0=4, predict_o=120; slots 1..3 = 0.
  - Before the 116 edge, period_valid_o=0.
- Alternating +1/+3:
  - Stimulus: 0, 1, 4, 5, 8, 9, 12, 13, 16.
  - Response: period-1 conf stays 0. After 16: period_o=2, slot0=1, slot1=3, predict_o=17.
  - Then feed 17 -> slot0=3, predict_o=20.
- Negative stride:
  - Stimulus: 50, 48, 46, 44, 42.
  - Response: period_o=1, slot0=5'b11110, predict_o=40.
  - Wrap check: 3, 1, 0xFFFFFFFF, 0xFFFFFFFD, 0xFFFFFFFB -> predict_o=0xFFFFFFF9.
- Overflow:
  - Stimulus: 0, 16, 32, 48, 64, 80 (stride 16 > 15).
  - Response: period_valid_o stays 0; all slots and confidences remain 0.
  - Stride -16 (e.g. 64, 48, 32, 16, 0): locks with slot0=5'b10000.
- Decay:
  - Stimulus: lock as in the first scenario, then value 123 (stride +7).
  - Response: period-1 conf=2, period_valid_o=0, stride slot unchanged.
  - Then 127, 131 -> period_valid_o=1 again with slot0=4.
- Clear and reset mid-stream:
  - Stimulus: while locked, assert clear_i together with valid_i, value 999.
  - Response: next cycle all outputs 0; next sample 500 only primes (still unlocked).
  - Asserting rst_ni low mid-stream clears all outputs immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/periodic_stride_detector.sv
// periodic_stride_detector
//
// Learns repeating stride patterns of period 1..MAX_PERIOD from a stream of
// 32-bit sample values. One detector per period P keeps P signed stride slots,
// P saturating confidence counters and a phase pointer. The shortest period
// whose confidences are all saturated is reported, with its strides rotated
// so that slot 0 is the next expected stride, along with a predicted next value.
//
// Handshake: valid_i qualifies value_i for exactly one clock. There is no
// backpressure; every strobed sample is consumed on the edge it is presented.
// clear_i flushes all learned state on the edge and overrides valid_i.
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   value_i          sample value
//   valid_i          sample strobe
//   clear_i          synchronous flush of all learned state
//   period_o         shortest locked period, 0 when none
//   period_valid_o   some detector is fully locked
//   stride_o         slot i in bits [i*SW +: SW]; slot 0 = next expected stride
//   predict_o        predicted next value_i (0 when unlocked)
//   predict_valid_o  same as period_valid_o

module periodic_stride_detector #(
    parameter int STRIDE_WIDTH = 5,
    parameter int MAX_PERIOD   = 4,
    parameter int CONF_WIDTH   = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [31:0]                           value_i,
    input  logic                                  valid_i,
    input  logic                                  clear_i,
    output logic [$clog2(MAX_PERIOD+1)-1:0]       period_o,
    output logic                                  period_valid_o,
    output logic [MAX_PERIOD*STRIDE_WIDTH-1:0]    stride_o,
    output logic [31:0]                           predict_o,
    output logic                                  predict_valid_o
);

    localparam int SW   = STRIDE_WIDTH;
    localparam int MP   = MAX_PERIOD;
    localparam int CW   = CONF_WIDTH;
    localparam int PW   = $clog2(MAX_PERIOD+1);
    localparam int PH_W = (MAX_PERIOD > 1) ? $clog2(MAX_PERIOD) : 1;
    localparam logic [CW-1:0] CONF_MAX = '1;

    // Detector d (0-based) tracks period P = d+1 and only uses slots 0..d;
    // the remaining slots stay at zero forever.
    logic [31:0]                        last_value_q, last_value_d;
    logic                               primed_q, primed_d;
    logic [MP-1:0][PH_W-1:0]            phase_q, phase_d;
    logic [MP-1:0][MP-1:0][SW-1:0]      stride_q, stride_d;
    logic [MP-1:0][MP-1:0][CW-1:0]      conf_q, conf_d;

    // Incoming stride, evaluated as a signed 33-bit difference so that a
    // step across the 2^32 boundary in either direction is still small.
    logic [32:0]   inc_full;
    logic          overflow;
    logic [SW-1:0] inc;

    assign inc_full = {value_i[31], value_i} - {last_value_q[31], last_value_q};
    // Representable in SW signed bits only if the sign bit and everything
    // above it agree.
    assign overflow = !((&inc_full[32:SW-1]) || !(|inc_full[32:SW-1]));
    assign inc      = inc_full[SW-1:0];

    // ------------------------------------------------------------------
    // Next-state / training
    // ------------------------------------------------------------------
    always_comb begin
        logic [PH_W-1:0] slot;
        last_value_d = last_value_q;
        primed_d     = primed_q;
        phase_d      = phase_q;
        stride_d     = stride_q;
        conf_d       = conf_q;
        slot         = '0;

        if (clear_i) begin
            last_value_d = '0;
            primed_d     = 1'b0;
            phase_d      = '0;
            stride_d     = '0;
            conf_d       = '0;
        end else if (valid_i) begin
            last_value_d = value_i;
            primed_d     = 1'b1;
            // The first sample after reset/clear has no predecessor, so it
            // only seeds last_value.
            if (primed_q) begin
                for (int d = 0; d < MP; d++) begin
                    slot = phase_q[d];
                    if (!overflow && (inc == stride_q[d][slot])) begin
                        if (conf_q[d][slot] != CONF_MAX) begin
                            conf_d[d][slot] = conf_q[d][slot] + 1'b1;
                        end
                    end else if (conf_q[d][slot] != '0) begin
                        conf_d[d][slot] = conf_q[d][slot] - 1'b1;
                    end else if (!overflow) begin
                        stride_d[d][slot] = inc;
                    end
                    phase_d[d] = (phase_q[d] == PH_W'(d)) ? '0 : phase_q[d] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_value_q <= '0;
            primed_q     <= 1'b0;
            phase_q      <= '0;
            stride_q     <= '0;
            conf_q       <= '0;
        end else begin
            last_value_q <= last_value_d;
            primed_q     <= primed_d;
            phase_q      <= phase_d;
            stride_q     <= stride_d;
            conf_q       <= conf_d;
        end
    end

    // ------------------------------------------------------------------
    // Lock detection and selection of the shortest locked period
    // ------------------------------------------------------------------
    logic [MP-1:0] locked;

    always_comb begin
        locked = '1;
        for (int d = 0; d < MP; d++) begin
            for (int s = 0; s < MP; s++) begin
                if ((s <= d) && (conf_q[d][s] != CONF_MAX)) begin
                    locked[d] = 1'b0;
                end
            end
        end
    end

    logic          sel_found;
    int            sel_d;
    logic [SW-1:0] slot0;

    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel_d     = 0;
        idx       = 0;
        for (int d = 0; d < MP; d++) begin
            if (!sel_found && locked[d]) begin
                sel_found = 1'b1;
                sel_d     = d;
            end
        end

        // Rotate the selected detector's slots so slot 0 is the stride that
        // the next sample is expected to show.
        stride_o = '0;
        if (sel_found) begin
            for (int i = 0; i < MP; i++) begin
                if (i <= sel_d) begin
                    idx = int'(phase_q[sel_d]) + i;
                    if (idx > sel_d) begin
                        idx = idx - (sel_d + 1);
                    end
                    stride_o[i*SW +: SW] = stride_q[sel_d][idx];
                end
            end
        end
    end

    assign slot0           = stride_o[SW-1:0];
    assign period_valid_o  = sel_found;
    assign predict_valid_o = sel_found;
    assign period_o        = sel_found ? PW'(sel_d + 1) : '0;
    assign predict_o       = sel_found ? (last_value_q + {{(32-SW){slot0[SW-1]}}, slot0}) : '0;

endmodule
